// File: rtl/riscv_pkg.sv
// Shared RISC-V EX-stage types: branch condition encodings, BTB entry layout, PC step.
package riscv_pkg;

  localparam int PC_STEP = 4;

  typedef enum logic [2:0] {
    BRANCH_BEQ  = 3'b000,
    BRANCH_BNE  = 3'b001,
    BRANCH_BLT  = 3'b100,
    BRANCH_BGE  = 3'b101,
    BRANCH_BLTU = 3'b110,
    BRANCH_BGEU = 3'b111
  } branch_op_t;

  // Entry layout for the default 64-bit PC, 16-entry, 2-bit-counter configuration.
  localparam int BTB_DEF_DATA_W = 64;
  localparam int BTB_DEF_TAG_W  = 58;
  localparam int BTB_DEF_CNT_W  = 2;

  typedef struct packed {
    logic                      valid;
    logic [BTB_DEF_TAG_W-1:0]  tag;
    logic [BTB_DEF_DATA_W-1:0] target;
    logic [BTB_DEF_CNT_W-1:0]  cnt;
  } btb_entry_t;

endpackage

// File: rtl/riscv_ex_btb.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Lookup is combinational from registered state; updates land on the clock edge.
module riscv_ex_btb
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_WIDTH   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_lookup_pc,
  output logic                  o_hit,
  output logic                  o_taken,
  output logic [DATA_WIDTH-1:0] o_target,
  input  logic                  i_upd_en,
  input  logic                  i_upd_jump,
  input  logic                  i_upd_taken,
  input  logic [DATA_WIDTH-1:0] i_upd_pc,
  input  logic [DATA_WIDTH-1:0] i_upd_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;
  localparam logic [CNT_WIDTH-1:0] CNT_WEAK = CNT_WIDTH'(1) << (CNT_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [CNT_WIDTH-1:0]   cnt_q    [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0]  target_q [BTB_ENTRIES];

  logic [IDX_W-1:0]      lk_idx, upd_idx;
  logic [TAG_W-1:0]      lk_tag, upd_tag;
  logic                  upd_hit, upd_we;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic [DATA_WIDTH-1:0] target_d;
  logic                  pc_lsb_unused;

  // Instruction-aligned PCs: the two low bits never participate in indexing.
  assign pc_lsb_unused = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

  assign lk_idx  = i_lookup_pc[IDX_W+1:2];
  assign lk_tag  = i_lookup_pc[DATA_WIDTH-1:IDX_W+2];
  assign upd_idx = i_upd_pc[IDX_W+1:2];
  assign upd_tag = i_upd_pc[DATA_WIDTH-1:IDX_W+2];

  assign o_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign o_taken  = o_hit && cnt_q[lk_idx][CNT_WIDTH-1];
  assign o_target = o_hit ? target_q[lk_idx] : '0;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    upd_we   = 1'b0;
    cnt_d    = cnt_q[upd_idx];
    target_d = target_q[upd_idx];
    if (i_upd_en) begin
      if (upd_hit) begin
        upd_we = 1'b1;
        if (i_upd_jump) begin
          cnt_d    = CNT_MAX;
          target_d = i_upd_target;
        end else begin
          if (i_upd_taken && cnt_q[upd_idx] != CNT_MAX) cnt_d = cnt_q[upd_idx] + 1'b1;
          else if (!i_upd_taken && cnt_q[upd_idx] != '0) cnt_d = cnt_q[upd_idx] - 1'b1;
          if (i_upd_taken) target_d = i_upd_target;
        end
      end else if (i_upd_taken) begin
        upd_we   = 1'b1;
        cnt_d    = i_upd_jump ? CNT_MAX : CNT_WEAK;
        target_d = i_upd_target;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) cnt_q[i] <= '0;
    end else if (upd_we) begin
      valid_q[upd_idx] <= 1'b1;
      cnt_q[upd_idx]   <= cnt_d;
    end
  end

  // Tag and target need no reset: they are qualified by the valid bit.
  always_ff @(posedge i_clk) begin
    if (upd_we) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= target_d;
    end
  end

endmodule

// File: rtl/riscv_ex_branch_predict_unit.sv
// EX-stage branch/jump resolver: condition compare, target generation, mispredict
// redirect, BTB training and performance counters.
module riscv_ex_branch_predict_unit
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_WIDTH   = 2,
  parameter int PERF_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_if_pc,
  output logic                  o_pred_hit,
  output logic                  o_pred_taken,
  output logic [DATA_WIDTH-1:0] o_pred_target,
  input  logic                  i_ex_valid,
  input  logic                  i_ex_branch,
  input  logic                  i_ex_jump,
  input  logic                  i_ex_pc_src,
  input  logic [2:0]            i_ex_branch_op,
  input  logic [DATA_WIDTH-1:0] i_ex_pc,
  input  logic [DATA_WIDTH-1:0] i_ex_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_ex_rs2_data,
  input  logic [DATA_WIDTH-1:0] i_ex_imm_data,
  input  logic                  i_ex_pred_taken,
  input  logic [DATA_WIDTH-1:0] i_ex_pred_target,
  output logic                  o_jump_branch,
  output logic                  o_redirect,
  output logic [DATA_WIDTH-1:0] o_redirect_pc,
  output logic [PERF_WIDTH-1:0] o_branch_cnt,
  output logic [PERF_WIDTH-1:0] o_mispredict_cnt
);

  branch_op_t            op;
  logic                  eq, lt_s, lt_u, cond, taken, resolve, mispredict;
  logic [DATA_WIDTH-1:0] target, seq_pc, next_pc;

  logic                  redirect_q, redirect_d;
  logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [PERF_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [PERF_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

  assign op   = branch_op_t'(i_ex_branch_op);
  assign eq   = (i_ex_rs1_data == i_ex_rs2_data);
  assign lt_s = ($signed(i_ex_rs1_data) < $signed(i_ex_rs2_data));
  assign lt_u = (i_ex_rs1_data < i_ex_rs2_data);

  always_comb begin
    cond = 1'b0;
    case (op)
      BRANCH_BEQ:  cond = eq;
      BRANCH_BNE:  cond = !eq;
      BRANCH_BLT:  cond = lt_s;
      BRANCH_BGE:  cond = !lt_s;
      BRANCH_BLTU: cond = lt_u;
      BRANCH_BGEU: cond = !lt_u;
      default:     cond = 1'b0;
    endcase
  end

  assign taken  = i_ex_jump || (i_ex_branch && cond);
  assign target = i_ex_pc_src ? ((i_ex_rs1_data + i_ex_imm_data) & ~DATA_WIDTH'(1))
                              : (i_ex_pc + i_ex_imm_data);
  assign seq_pc  = i_ex_pc + DATA_WIDTH'(PC_STEP);
  assign next_pc = taken ? target : seq_pc;

  assign resolve    = i_ex_valid && (i_ex_branch || i_ex_jump);
  assign mispredict = resolve && ((taken != i_ex_pred_taken) ||
                                  (taken && (target != i_ex_pred_target)));

  assign o_jump_branch = taken;

  riscv_ex_btb #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BTB_ENTRIES (BTB_ENTRIES),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_btb (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_lookup_pc  (i_if_pc),
    .o_hit        (o_pred_hit),
    .o_taken      (o_pred_taken),
    .o_target     (o_pred_target),
    .i_upd_en     (resolve),
    .i_upd_jump   (i_ex_jump),
    .i_upd_taken  (taken),
    .i_upd_pc     (i_ex_pc),
    .i_upd_target (target)
  );

  always_comb begin
    redirect_d    = mispredict;
    redirect_pc_d = mispredict ? next_pc : redirect_pc_q;
    branch_cnt_d  = resolve ? branch_cnt_q + 1'b1 : branch_cnt_q;
    mispred_cnt_d = mispredict ? mispred_cnt_q + 1'b1 : mispred_cnt_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_redirect       = redirect_q;
  assign o_redirect_pc    = redirect_pc_q;
  assign o_branch_cnt     = branch_cnt_q;
  assign o_mispredict_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_riscv_ex_branch_predict_unit.sv
// Directed bench for riscv_ex_branch_predict_unit: hand-computed expectations per scenario.
module tb_riscv_ex_branch_predict_unit;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk, rst_n;
  logic [63:0] if_pc;
  logic        pred_hit, pred_taken;
  logic [63:0] pred_target;
  logic        ex_valid, ex_branch, ex_jump, ex_pc_src;
  logic [2:0]  ex_op;
  logic [63:0] ex_pc, ex_rs1, ex_rs2, ex_imm, ex_ptarget;
  logic        ex_ptaken;
  logic        jump_branch, redirect;
  logic [63:0] redirect_pc;
  logic [31:0] branch_cnt, mispredict_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  riscv_ex_branch_predict_unit dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_if_pc          (if_pc),
    .o_pred_hit       (pred_hit),
    .o_pred_taken     (pred_taken),
    .o_pred_target    (pred_target),
    .i_ex_valid       (ex_valid),
    .i_ex_branch      (ex_branch),
    .i_ex_jump        (ex_jump),
    .i_ex_pc_src      (ex_pc_src),
    .i_ex_branch_op   (ex_op),
    .i_ex_pc          (ex_pc),
    .i_ex_rs1_data    (ex_rs1),
    .i_ex_rs2_data    (ex_rs2),
    .i_ex_imm_data    (ex_imm),
    .i_ex_pred_taken  (ex_ptaken),
    .i_ex_pred_target (ex_ptarget),
    .o_jump_branch    (jump_branch),
    .o_redirect       (redirect),
    .o_redirect_pc    (redirect_pc),
    .o_branch_cnt     (branch_cnt),
    .o_mispredict_cnt (mispredict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic ex_set(input logic br, input logic jmp, input logic src, input logic [2:0] op,
                        input logic [63:0] pc, input logic [63:0] rs1, input logic [63:0] rs2,
                        input logic [63:0] imm, input logic pt, input logic [63:0] ptgt);
    ex_valid = 1'b1; ex_branch = br; ex_jump = jmp; ex_pc_src = src; ex_op = op;
    ex_pc = pc; ex_rs1 = rs1; ex_rs2 = rs2; ex_imm = imm; ex_ptaken = pt; ex_ptarget = ptgt;
  endtask

  task automatic ex_idle();
    ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0; ex_pc_src = 1'b0; ex_op = 3'b000;
    ex_pc = '0; ex_rs1 = '0; ex_rs2 = '0; ex_imm = '0; ex_ptaken = 1'b0; ex_ptarget = '0;
  endtask

  task automatic test_reset();
    if_pc = 64'h100;
    #1;
    total_cnt++; if (pred_hit !== 1'b0) $display("FAIL reset_hit got=%0h exp=0", pred_hit); else pass_cnt++;
    total_cnt++; if (pred_taken !== 1'b0) $display("FAIL reset_taken got=%0h exp=0", pred_taken); else pass_cnt++;
    total_cnt++; if (pred_target !== 64'h0) $display("FAIL reset_target got=%0h exp=0", pred_target); else pass_cnt++;
    total_cnt++; if (redirect !== 1'b0) $display("FAIL reset_redirect got=%0h exp=0", redirect); else pass_cnt++;
    total_cnt++; if (redirect_pc !== 64'h0) $display("FAIL reset_redirect_pc got=%0h exp=0", redirect_pc); else pass_cnt++;
    total_cnt++; if (branch_cnt !== 32'd0 || mispredict_cnt !== 32'd0)
      $display("FAIL reset_perf got=%0d/%0d exp=0/0", branch_cnt, mispredict_cnt); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_beq_taken();
    @(negedge clk);
    ex_set(1'b1, 1'b0, 1'b0, 3'b000, 64'h100, 64'd5, 64'd5, 64'h20, 1'b0, 64'h0);
    #1;
    total_cnt++; if (jump_branch !== 1'b1) $display("FAIL beq_jump_branch got=%0h exp=1", jump_branch); else pass_cnt++;
    total_cnt++; if (redirect !== 1'b0) $display("FAIL beq_redirect_early got=%0h exp=0", redirect); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (redirect !== 1'b1) $display("FAIL beq_redirect got=%0h exp=1", redirect); else pass_cnt++;
    total_cnt++; if (redirect_pc !== 64'h120) $display("FAIL beq_redirect_pc got=%0h exp=120", redirect_pc); else pass_cnt++;
    total_cnt++; if (branch_cnt !== 32'd1 || mispredict_cnt !== 32'd1)
      $display("FAIL beq_perf got=%0d/%0d exp=1/1", branch_cnt, mispredict_cnt); else pass_cnt++;
    total_cnt++; if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 64'h120)
      $display("FAIL beq_lookup got=%0h/%0h/%0h exp=1/1/120", pred_hit, pred_taken, pred_target); else pass_cnt++;
    @(negedge clk); ex_idle();
    @(posedge clk); #1;
    total_cnt++; if (redirect !== 1'b0) $display("FAIL beq_pulse_len got=%0h exp=0", redirect); else pass_cnt++;
  endtask

  task automatic test_signed_unsigned();
    // BLTU 1 < all-ones: taken, allocates idx 1 with target 0x244.
    @(negedge clk);
    ex_set(1'b1, 1'b0, 1'b0, 3'b110, 64'h204, 64'd1, ONES, 64'h40, 1'b0, 64'h0);
    #1;
    total_cnt++; if (jump_branch !== 1'b1) $display("FAIL bltu_taken got=%0h exp=1", jump_branch); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (redirect !== 1'b1 || redirect_pc !== 64'h244)
      $display("FAIL bltu_redirect got=%0h/%0h exp=1/244", redirect, redirect_pc); else pass_cnt++;
    // BLT 1 < -1 is false: predicted taken, so fall through to pc+4.
    @(negedge clk);
    ex_set(1'b1, 1'b0, 1'b0, 3'b100, 64'h204, 64'd1, ONES, 64'h40, 1'b1, 64'h244);
    #1;
    total_cnt++; if (jump_branch !== 1'b0) $display("FAIL blt_not_taken got=%0h exp=0", jump_branch); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (redirect !== 1'b1 || redirect_pc !== 64'h208)
      $display("FAIL blt_redirect got=%0h/%0h exp=1/208", redirect, redirect_pc); else pass_cnt++;
    total_cnt++; if (branch_cnt !== 32'd3 || mispredict_cnt !== 32'd3)
      $display("FAIL blt_perf got=%0d/%0d exp=3/3", branch_cnt, mispredict_cnt); else pass_cnt++;
    if_pc = 64'h204; #1;
    total_cnt++; if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 64'h244)
      $display("FAIL blt_lookup got=%0h/%0h/%0h exp=1/0/244", pred_hit, pred_taken, pred_target); else pass_cnt++;
    @(negedge clk); ex_idle();
  endtask

  task automatic test_cond_ops();
    // ex_valid stays low: condition visible on o_jump_branch, no state change.
    logic [2:0]  ops [7] = '{3'b001, 3'b001, 3'b101, 3'b111, 3'b101, 3'b010, 3'b110};
    logic [63:0] a   [7] = '{64'd5, 64'd5, ONES, ONES, 64'd7, 64'd9, 64'd3};
    logic [63:0] b   [7] = '{64'd5, 64'd6, 64'd1, 64'd1, 64'd7, 64'd9, 64'd3};
    logic        exp [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ex_set(1'b1, 1'b0, 1'b0, ops[i], 64'h800, a[i], b[i], 64'h10, 1'b0, 64'h0);
      ex_valid = 1'b0;
      #1;
      total_cnt++; if (jump_branch !== exp[i])
        $display("FAIL cond_op%0d op=%b got=%0h exp=%0h", i, ops[i], jump_branch, exp[i]); else pass_cnt++;
    end
    @(posedge clk); #1;
    total_cnt++; if (redirect !== 1'b0 || branch_cnt !== 32'd3 || mispredict_cnt !== 32'd3)
      $display("FAIL cond_no_resolve got=%0h/%0d/%0d exp=0/3/3", redirect, branch_cnt, mispredict_cnt); else pass_cnt++;
    if_pc = 64'h800; #1;
    total_cnt++; if (pred_hit !== 1'b0) $display("FAIL cond_no_alloc got=%0h exp=0", pred_hit); else pass_cnt++;
    @(negedge clk); ex_idle();
  endtask

  task automatic test_jalr();
    @(negedge clk);
    ex_set(1'b0, 1'b1, 1'b1, 3'b000, 64'h308, 64'h203, 64'h0, 64'h0, 1'b0, 64'h0);
    #1;
    total_cnt++; if (jump_branch !== 1'b1) $display("FAIL jalr_taken got=%0h exp=1", jump_branch); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (redirect !== 1'b1 || redirect_pc !== 64'h202)
      $display("FAIL jalr_redirect got=%0h/%0h exp=1/202", redirect, redirect_pc); else pass_cnt++;
    if_pc = 64'h308; #1;
    total_cnt++; if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 64'h202)
      $display("FAIL jalr_lookup got=%0h/%0h/%0h exp=1/1/202", pred_hit, pred_taken, pred_target); else pass_cnt++;
    @(negedge clk);
    ex_set(1'b0, 1'b1, 1'b1, 3'b000, 64'h308, 64'h203, 64'h0, 64'h0, 1'b1, 64'h202);
    @(posedge clk); #1;
    total_cnt++; if (redirect !== 1'b0 || branch_cnt !== 32'd5 || mispredict_cnt !== 32'd4)
      $display("FAIL jalr_correct got=%0h/%0d/%0d exp=0/5/4", redirect, branch_cnt, mispredict_cnt); else pass_cnt++;
    // A not-taken branch on the jump's entry leaves an all-ones counter still taken.
    @(negedge clk);
    ex_set(1'b1, 1'b0, 1'b0, 3'b000, 64'h308, 64'd0, 64'd1, 64'h40, 1'b1, 64'h202);
    @(posedge clk); #1;
    total_cnt++; if (redirect !== 1'b1 || redirect_pc !== 64'h30C)
      $display("FAIL jalr_nt_redirect got=%0h/%0h exp=1/30c", redirect, redirect_pc); else pass_cnt++;
    total_cnt++; if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 64'h202)
      $display("FAIL jalr_cnt_max got=%0h/%0h/%0h exp=1/1/202", pred_hit, pred_taken, pred_target); else pass_cnt++;
    @(negedge clk); ex_idle();
  endtask

  task automatic test_saturate();
    logic pt [3] = '{1'b1, 1'b0, 1'b0};
    @(negedge clk);
    ex_set(1'b1, 1'b0, 1'b0, 3'b000, 64'h410, 64'd0, 64'd0, 64'h10, 1'b0, 64'h0);
    @(posedge clk); #1;
    total_cnt++; if (redirect !== 1'b1 || redirect_pc !== 64'h420)
      $display("FAIL sat_alloc got=%0h/%0h exp=1/420", redirect, redirect_pc); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ex_set(1'b1, 1'b0, 1'b0, 3'b000, 64'h410, 64'd0, 64'd1, 64'h10, pt[i], 64'h420);
      @(posedge clk); #1;
      total_cnt++; if (redirect !== pt[i]) $display("FAIL sat_nt%0d_redirect got=%0h exp=%0h", i, redirect, pt[i]); else pass_cnt++;
    end
    if_pc = 64'h410; #1;
    total_cnt++; if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 64'h420)
      $display("FAIL sat_lookup got=%0h/%0h/%0h exp=1/0/420", pred_hit, pred_taken, pred_target); else pass_cnt++;
    total_cnt++; if (branch_cnt !== 32'd10 || mispredict_cnt !== 32'd7)
      $display("FAIL sat_perf got=%0d/%0d exp=10/7", branch_cnt, mispredict_cnt); else pass_cnt++;
    @(negedge clk); ex_idle();
  endtask

  task automatic test_back_to_back();
    // 0x600 and 0x640 share index 0 and differ only in tag.
    @(negedge clk);
    ex_set(1'b1, 1'b0, 1'b0, 3'b000, 64'h600, 64'd0, 64'd0, 64'h8, 1'b0, 64'h0);
    @(posedge clk); #1;
    total_cnt++; if (redirect !== 1'b1 || redirect_pc !== 64'h608)
      $display("FAIL b2b_first got=%0h/%0h exp=1/608", redirect, redirect_pc); else pass_cnt++;
    @(negedge clk);
    ex_set(1'b1, 1'b0, 1'b0, 3'b000, 64'h640, 64'd0, 64'd0, 64'h10, 1'b0, 64'h0);
    @(posedge clk); #1;
    total_cnt++; if (redirect !== 1'b1 || redirect_pc !== 64'h650)
      $display("FAIL b2b_second got=%0h/%0h exp=1/650", redirect, redirect_pc); else pass_cnt++;
    if_pc = 64'h600; #1;
    total_cnt++; if (pred_hit !== 1'b0) $display("FAIL alias_evicted got=%0h exp=0", pred_hit); else pass_cnt++;
    if_pc = 64'h640; #1;
    total_cnt++; if (pred_hit !== 1'b1 || pred_target !== 64'h650)
      $display("FAIL alias_new got=%0h/%0h exp=1/650", pred_hit, pred_target); else pass_cnt++;
    total_cnt++; if (branch_cnt !== 32'd12 || mispredict_cnt !== 32'd9)
      $display("FAIL b2b_perf got=%0d/%0d exp=12/9", branch_cnt, mispredict_cnt); else pass_cnt++;
    @(negedge clk); ex_idle();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    ex_set(1'b1, 1'b0, 1'b0, 3'b000, 64'h700, 64'd0, 64'd0, 64'h4, 1'b0, 64'h0);
    @(posedge clk); #1;
    total_cnt++; if (redirect !== 1'b1 || redirect_pc !== 64'h704)
      $display("FAIL arst_pre got=%0h/%0h exp=1/704", redirect, redirect_pc); else pass_cnt++;
    ex_idle();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (redirect !== 1'b0 || redirect_pc !== 64'h0)
      $display("FAIL arst_redirect got=%0h/%0h exp=0/0", redirect, redirect_pc); else pass_cnt++;
    total_cnt++; if (branch_cnt !== 32'd0 || mispredict_cnt !== 32'd0)
      $display("FAIL arst_perf got=%0d/%0d exp=0/0", branch_cnt, mispredict_cnt); else pass_cnt++;
    if_pc = 64'h640; #0.1;
    total_cnt++; if (pred_hit !== 1'b0 || pred_target !== 64'h0)
      $display("FAIL arst_lookup640 got=%0h/%0h exp=0/0", pred_hit, pred_target); else pass_cnt++;
    if_pc = 64'h308; #0.1;
    total_cnt++; if (pred_hit !== 1'b0 || pred_taken !== 1'b0)
      $display("FAIL arst_lookup308 got=%0h/%0h exp=0/0", pred_hit, pred_taken); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    if_pc = '0;
    ex_idle();
    repeat (2) @(posedge clk);
    test_reset();
    test_beq_taken();
    test_signed_unsigned();
    test_cond_ops();
    test_jalr();
    test_saturate();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/riscv_ex_branch_predict_unit.md
# riscv_ex_branch_predict_unit

Execute-stage branch/jump resolution unit with an integrated direct-mapped branch target buffer (BTB) and per-entry saturating direction counters. It supplies a next-PC prediction to fetch and resolves every control-transfer instruction in EX. On a wrong prediction it issues a registered one-cycle redirect, and it trains the BTB. It supersedes the flag-based EX jump/branch resolver: it compares operands internally, supports all six RV conditional branches, and keeps performance counters.

## Interface
Parameters:
- DATA_WIDTH, 64, width of PC and operands.
- BTB_ENTRIES, 16, number of BTB entries; power of two, ≥2. IDX_W = log2(BTB_ENTRIES).
- CNT_WIDTH, 2, direction counter width, ≥1.
- PERF_WIDTH, 32, width of performance counters.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_if_pc  in  DATA_WIDTH  fetch PC to predict.
- o_pred_hit  out  1  BTB tag match for i_if_pc.
- o_pred_taken  out  1  prediction is taken: hit AND counter MSB set.
- o_pred_target  out  DATA_WIDTH  predicted target; 0 when not hit.
- i_ex_valid  in  1  EX holds a valid instruction.
- i_ex_branch  in  1  conditional branch.
- i_ex_jump  in  1  JAL/JALR.
- i_ex_pc_src  in  1  1 selects rs1+imm as target (JALR), 0 selects pc+imm.
- i_ex_branch_op  in  3  branch_op_t (funct3 encoding).
- i_ex_pc, i_ex_rs1_data, i_ex_rs2_data, i_ex_imm_data  in  DATA_WIDTH  EX operands.
- i_ex_pred_taken  in  1  prediction piped from IF with this instruction.
- i_ex_pred_target  in  DATA_WIDTH  target piped from IF with this instruction.
- o_jump_branch  out  1  actual taken, combinational.
- o_redirect  out  1  registered mispredict pulse.
- o_redirect_pc  out  DATA_WIDTH  correct next PC, registered.
- o_branch_cnt  out  PERF_WIDTH  resolved control transfers.
- o_mispredict_cnt  out  PERF_WIDTH  mispredictions.

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[DATA_WIDTH-1:IDX_W+2]. Entry fields: valid, tag, target, counter.
- Lookup (IF) is combinational from registered state. There is no bypass, so a same-cycle update is not visible to lookup.
- Condition evaluation:
  - BEQ: eq. BNE: !eq.
  - BLT: signed <. BGE: signed ≥.
  - BLTU: unsigned <. BGEU: unsigned ≥.
  - Reserved ops (010, 011) evaluate to 0.
- Actual taken = i_ex_jump OR (i_ex_branch AND cond).
- Target = i_ex_pc_src ? (rs1+imm) with bit0 cleared : pc+imm. All additions are modulo 2^DATA_WIDTH.
- Resolve is active when i_ex_valid AND (branch OR jump). Mispredict = (taken ≠ i_ex_pred_taken) OR (taken AND target ≠ i_ex_pred_target).
- Correct next PC = taken ? target : pc+4.
- Update on resolve:
  - Hit, branch: counter increments on taken, decrements on not-taken, saturating at all-ones and 0. Target rewritten if taken.
  - Hit, jump: counter set to all-ones, target rewritten.
  - Miss and taken: allocate (overwrite) with valid=1, tag, target. Counter = weakly taken (MSB=1, rest 0) for a branch, all-ones for a jump.
  - Miss and not-taken: no change.
- Resolve with i_ex_valid=0, or with neither branch nor jump: no state change and no counting.
- o_branch_cnt increments on each resolve. o_mispredict_cnt increments on each mispredict. Both wrap at 2^PERF_WIDTH.

## Timing
- Reset values: all valid bits 0, counters 0, o_redirect 0, o_redirect_pc 0, both perf counters 0. Hence o_pred_hit, o_pred_taken and o_pred_target are all 0.
- Reset is asynchronous: assertion mid-operation clears state immediately, and an in-flight redirect is dropped.
- BTB and perf updates land on the rising edge that ends the resolve cycle.
- o_redirect asserts exactly one cycle after the mispredicting EX cycle and lasts one cycle. o_redirect_pc is valid with it.
- Back-to-back mispredicts produce back-to-back pulses, each carrying its own PC.
- o_jump_branch has zero latency (same cycle as EX).

## Structure
- riscv_pkg gains branch_op_t with 3-bit values BRANCH_BEQ=000, BRANCH_BNE=001, BRANCH_BLT=100, BRANCH_BGE=101, BRANCH_BLTU=110, BRANCH_BGEU=111. It also gains a btb_entry_t struct template and PC_STEP=4.
- One sub-module, riscv_ex_btb, holds storage, lookup, and update/allocate. The top module holds compare, target, mispredict, redirect and perf logic.

## Test plan
- Reset, then i_if_pc=0x100 → o_pred_hit=0, o_pred_taken=0, o_pred_target=0.
- BEQ at pc=0x100 with rs1=rs2=5, imm=0x20, pred_taken=0 → next cycle o_redirect=1 and o_redirect_pc=0x120. Lookup of 0x100 then gives hit=1, taken=1, target=0x120. Perf counters read 1/1.
- BLTU with rs1=1, rs2=0xFFFF…FF → taken. BLT with the same operands → not taken; a pred_taken=1 entry yields o_redirect_pc=pc+4.
- JALR with rs1=0x203, imm=0 → target 0x202, counter all-ones. A repeat with pred_taken=1 and pred_target=0x202 gives no redirect.
- Same branch not taken three times from the weakly taken state → counter saturates at 0 and o_pred_taken=0 with hit=1. Two pcs differing only in tag alias one index; the second allocation evicts the first.
- Pulse i_rst_n low in the cycle after a mispredict → o_redirect drops immediately and all BTB entries read as miss.
